capture_ring_buffer: RTL and testbench

Parametrised multi-channel capture memory for the logic analyzer data path. It replaces the 1-bit single-port sample RAM with a CHANNELS-wide circular buffer that runs a pre-trigger/post-trigger capture sequence. After capture, it streams samples out oldest-first with one-cycle read latency. It sits between the channel sampler/trigger unit and the host readout interface.

---
 rtl/capture_ring_buffer.sv | 111 +++++++++++
 tb/tb_capture_ring_buffer.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/capture_ring_buffer.sv
// capture_ring_buffer: CHANNELS-wide circular capture memory with pre/post-trigger
// sequencing and oldest-first readout with one-cycle read latency.
module capture_ring_buffer #(
    parameter int CHANNELS   = 4,
    parameter int ADDR_WIDTH = 13
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  arm,
    input  logic                  sample_en,
    input  logic [CHANNELS-1:0]   din,
    input  logic                  trig,
    input  logic [ADDR_WIDTH-1:0] post_count,
    input  logic                  rd_en,
    output logic [CHANNELS-1:0]   rd_data,
    output logic                  rd_valid,
    output logic                  rd_last,
    output logic                  busy,
    output logic                  done,
    output logic                  wrapped,
    output logic [ADDR_WIDTH-1:0] trig_addr
);
    localparam int D = 1 << ADDR_WIDTH;
    typedef enum logic [2:0] {IDLE, FILL, POST, DONE, READ} state_t;
    state_t                state;
    logic [CHANNELS-1:0]   mem [D];
    logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr, post_cnt, post_lim, wr_nxt, done_ptr;
    logic [ADDR_WIDTH:0]   fill, fill_nxt, remaining;
    logic                  wr_en, wrap_nxt, last_rd;
    assign wr_en    = sample_en && (state == FILL || state == POST);
    assign wr_nxt   = wr_ptr + 1'b1;
    assign wrap_nxt = wrapped || (wr_ptr == '1);
    assign fill_nxt = (fill == (ADDR_WIDTH+1)'(D)) ? fill : fill + 1'b1;
    // Oldest sample once the write that ends the capture has landed
    assign done_ptr = wrap_nxt ? wr_nxt : '0;
    assign last_rd  = remaining == (ADDR_WIDTH+1)'(1);
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= din;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            fill      <= '0;
            remaining <= '0;
            post_cnt  <= '0;
            post_lim  <= '0;
            trig_addr <= '0;
            rd_data   <= '0;
            rd_valid  <= 1'b0;
            rd_last   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            wrapped   <= 1'b0;
        end else begin
            rd_valid <= 1'b0;
            rd_last  <= 1'b0;
            if (wr_en) begin
                wr_ptr  <= wr_nxt;
                wrapped <= wrap_nxt;
                fill    <= fill_nxt;
            end
            if (arm && (state == IDLE || state == DONE || state == READ)) begin
                state    <= FILL;
                busy     <= 1'b1;
                done     <= 1'b0;
                wr_ptr   <= '0;
                fill     <= '0;
                wrapped  <= 1'b0;
                post_lim <= post_count;
            end else begin
                case (state)
                    FILL: if (sample_en && trig) begin
                        trig_addr <= wr_ptr;
                        post_cnt  <= post_lim;
                        if (post_lim == '0) begin
                            state     <= DONE;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            rd_ptr    <= done_ptr;
                            remaining <= fill_nxt;
                        end else begin
                            state <= POST;
                        end
                    end
                    POST: if (sample_en) begin
                        post_cnt <= post_cnt - 1'b1;
                        if (post_cnt == ADDR_WIDTH'(1)) begin
                            state     <= DONE;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            rd_ptr    <= done_ptr;
                            remaining <= fill_nxt;
                        end
                    end
                    DONE, READ: if (rd_en && remaining != '0) begin
                        state     <= last_rd ? IDLE : READ;
                        done      <= !last_rd;
                        rd_data   <= mem[rd_ptr];
                        rd_valid  <= 1'b1;
                        rd_last   <= last_rd;
                        rd_ptr    <= rd_ptr + 1'b1;
                        remaining <= remaining - 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_capture_ring_buffer.sv
// tb_capture_ring_buffer: directed capture/readout scenarios with a queue scoreboard
// of expected readout samples.
module tb_capture_ring_buffer;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       arm = 1'b0;
    logic       sample_en = 1'b0;
    logic [3:0] din = '0;
    logic       trig = 1'b0;
    logic [3:0] post_count = '0;
    logic       rd_en = 1'b0;
    logic [3:0] rd_data;
    logic       rd_valid, rd_last, busy, done, wrapped;
    logic [3:0] trig_addr;
    logic [3:0] q[$];
    int         tests = 0;
    int         fails = 0;

    capture_ring_buffer #(.CHANNELS(4), .ADDR_WIDTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .arm(arm), .sample_en(sample_en), .din(din),
        .trig(trig), .post_count(post_count), .rd_en(rd_en), .rd_data(rd_data),
        .rd_valid(rd_valid), .rd_last(rd_last), .busy(busy), .done(done),
        .wrapped(wrapped), .trig_addr(trig_addr)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_arm(input logic [3:0] pc);
        arm = 1'b1;
        post_count = pc;
        tick;
        arm = 1'b0;
    endtask

    task automatic samp(input int idx, input logic t);
        sample_en = 1'b1;
        din = 4'(idx);
        trig = t;
        tick;
        sample_en = 1'b0;
        trig = 1'b0;
    endtask

    task automatic push_range(input int first, input int last);
        for (int i = first; i <= last; i++) q.push_back(4'(i));
    endtask

    task automatic read_n(input string tag, input int n);
        logic [3:0] e;
        chk({tag, " queue_len"}, q.size(), n);
        rd_en = 1'b1;
        for (int i = 0; i < n; i++) begin
            tick;
            e = (q.size() != 0) ? q.pop_front() : 4'h0;
            chk({tag, " rd_valid"}, rd_valid, 1);
            chk({tag, " rd_data"}, rd_data, e);
            chk({tag, " rd_last"}, rd_last, i == n - 1);
        end
        tick;
        chk({tag, " extra_rd_valid"}, rd_valid, 0);
        chk({tag, " idle_done"}, done, 0);
        chk({tag, " idle_busy"}, busy, 0);
        rd_en = 1'b0;
    endtask

    task automatic scenario1(input string tag);
        do_arm(4'd3);
        chk({tag, " busy_after_arm"}, busy, 1);
        for (int i = 0; i < 5; i++) samp(i, 1'b0);
        samp(5, 1'b1);
        samp(6, 1'b0);
        samp(7, 1'b0);
        chk({tag, " busy_in_post"}, busy, 1);
        samp(8, 1'b0);
        chk({tag, " done"}, done, 1);
        chk({tag, " busy_cleared"}, busy, 0);
        chk({tag, " trig_addr"}, trig_addr, 5);
        chk({tag, " wrapped"}, wrapped, 0);
        push_range(0, 8);
        read_n(tag, 9);
    endtask

    initial begin
        tick;
        tick;
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst wrapped", wrapped, 0);
        chk("rst trig_addr", trig_addr, 0);
        chk("rst rd_valid", rd_valid, 0);
        chk("rst rd_last", rd_last, 0);
        chk("rst rd_data", rd_data, 0);
        #2 rst_n = 1'b1;
        tick;

        scenario1("s1");

        do_arm(4'd2);
        for (int i = 0; i < 20; i++) samp(i, 1'b0);
        samp(20, 1'b1);
        samp(21, 1'b0);
        samp(22, 1'b0);
        chk("s2 done", done, 1);
        chk("s2 wrapped", wrapped, 1);
        chk("s2 trig_addr", trig_addr, 4);
        push_range(7, 22);
        read_n("s2", 16);

        do_arm(4'd0);
        samp(0, 1'b1);
        chk("s3 done", done, 1);
        chk("s3 trig_addr", trig_addr, 0);
        push_range(0, 0);
        read_n("s3", 1);

        do_arm(4'hF);
        for (int i = 0; i < 3; i++) samp(i, 1'b0);
        samp(3, 1'b1);
        for (int i = 4; i < 18; i++) samp(i, 1'b0);
        chk("s4 busy_before_last", busy, 1);
        samp(18, 1'b0);
        chk("s4 done", done, 1);
        chk("s4 wrapped", wrapped, 1);
        chk("s4 trig_addr", trig_addr, 3);
        push_range(3, 18);
        read_n("s4", 16);

        trig = 1'b1;
        tick;
        trig = 1'b0;
        chk("s5 idle_trig busy", busy, 0);
        chk("s5 idle_trig done", done, 0);
        do_arm(4'd2);
        trig = 1'b1;
        tick;
        trig = 1'b0;
        chk("s5 nosample_trig busy", busy, 1);
        samp(0, 1'b0);
        rd_en = 1'b1;
        tick;
        rd_en = 1'b0;
        chk("s5 rd_in_fill valid", rd_valid, 0);
        samp(1, 1'b1);
        chk("s5 trig_addr", trig_addr, 1);
        arm = 1'b1;
        post_count = 4'd0;
        tick;
        arm = 1'b0;
        chk("s5 arm_in_post busy", busy, 1);
        chk("s5 arm_in_post done", done, 0);
        samp(2, 1'b0);
        chk("s5 post_mid busy", busy, 1);
        samp(3, 1'b0);
        chk("s5 post_end done", done, 1);
        push_range(0, 3);
        read_n("s5", 4);

        do_arm(4'd3);
        for (int i = 0; i < 5; i++) samp(i, 1'b0);
        samp(5, 1'b1);
        samp(6, 1'b0);
        chk("s6 busy_pre_reset", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("s6 async busy", busy, 0);
        chk("s6 async done", done, 0);
        chk("s6 async trig_addr", trig_addr, 0);
        #2 rst_n = 1'b1;
        tick;
        chk("s6 idle busy", busy, 0);
        scenario1("s6");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
